// File: rtl/branch_predictor_2bit_if.sv
// Branch predictor port bundle: fetch-side lookup, execute-side resolution
// update and the performance counters. The predictor is the slave side.
interface branch_predictor_2bit_if;
    logic [31:0] current_pc;
    logic        is_branch;
    logic        is_rv32c;
    logic [12:0] imm_sb;
    logic        predict_taken;
    logic [31:0] target_addr;
    logic        update_predictor;
    logic [31:0] pc_to_update;
    logic [31:0] update_addr;
    logic        branch_result;
    logic        prediction;
    logic        direction;
    logic [31:0] mispredict_count;
    logic [31:0] update_count;

    modport master (
        output current_pc, is_branch, is_rv32c, imm_sb,
        output update_predictor, pc_to_update, update_addr,
        output branch_result, prediction, direction,
        input  predict_taken, target_addr, mispredict_count, update_count
    );

    modport slave (
        input  current_pc, is_branch, is_rv32c, imm_sb,
        input  update_predictor, pc_to_update, update_addr,
        input  branch_result, prediction, direction,
        output predict_taken, target_addr, mispredict_count, update_count
    );
endinterface

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped table of tagged 2-bit saturating counters with stored targets.
// Misses fall back to backward-taken / forward-not-taken. Lookups are
// combinational from table state; updates land on the strobe edge.
module branch_predictor_2bit #(
    parameter int NENTRIES = 64
) (
    input logic                    clk,
    input logic                    rst,
    branch_predictor_2bit_if.slave bp
);
    localparam int IDX_W = $clog2(NENTRIES);
    localparam int TAG_W = 31 - IDX_W;

    logic [NENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q    [NENTRIES];
    logic [31:0]         target_q [NENTRIES];
    logic [1:0]          ctr_q    [NENTRIES];

    logic [31:0] upd_cnt;
    logic [31:0] misp_cnt;

    // Lookup side: bit 0 of the PC never selects an entry.
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [31:0]      imm_sext;

    assign rd_idx   = bp.current_pc[IDX_W:1];
    assign rd_tag   = bp.current_pc[31:1+IDX_W];
    assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign imm_sext = {{19{bp.imm_sb[12]}}, bp.imm_sb};

    // Update side.
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic [1:0]       ctr_next;

    assign wr_idx = bp.pc_to_update[IDX_W:1];
    assign wr_tag = bp.pc_to_update[31:1+IDX_W];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // direction is a reserved hint; pc_to_update[0] cannot index or tag.
    logic unused_bits;
    assign unused_bits = ^{bp.direction, bp.pc_to_update[0]};

    // Prediction: trained entry on a hit, static sign rule on a miss.
    always_comb begin
        bp.predict_taken = 1'b0;
        bp.target_addr   = bp.current_pc + (bp.is_rv32c ? 32'd2 : 32'd4);
        if (bp.is_branch) begin
            if (rd_hit) begin
                bp.predict_taken = ctr_q[rd_idx][1];
                bp.target_addr   = target_q[rd_idx];
            end else begin
                bp.predict_taken = bp.imm_sb[12];
                bp.target_addr   = bp.current_pc + imm_sext;
            end
        end
    end

    // Counter training; a fresh allocation starts weakly toward the outcome.
    always_comb begin
        ctr_next = bp.branch_result ? 2'b10 : 2'b01;
        if (wr_hit) begin
            ctr_next = ctr_q[wr_idx];
            if (bp.branch_result) begin
                if (ctr_q[wr_idx] != 2'b11) ctr_next = ctr_q[wr_idx] + 2'd1;
            end else begin
                if (ctr_q[wr_idx] != 2'b00) ctr_next = ctr_q[wr_idx] - 2'd1;
            end
        end
    end

    // Table state: reset clears everything and wins over a coincident strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (bp.update_predictor) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= bp.update_addr;
            ctr_q[wr_idx]    <= ctr_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt  <= '0;
            misp_cnt <= '0;
        end else if (bp.update_predictor) begin
            if (upd_cnt != 32'hFFFF_FFFF) upd_cnt <= upd_cnt + 32'd1;
            if ((bp.prediction != bp.branch_result) && (misp_cnt != 32'hFFFF_FFFF))
                misp_cnt <= misp_cnt + 32'd1;
        end
    end

    assign bp.update_count     = upd_cnt;
    assign bp.mispredict_count = misp_cnt;
endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Scoreboard bench: the stimulus process predicts every cycle's outputs from
// a table model and queues them; a monitor compares on the falling edge.
module tb_branch_predictor_2bit;
    localparam int NENT  = 64;
    localparam int IDX_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_2bit_if bif ();

    branch_predictor_2bit #(.NENTRIES(NENT)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif.slave)
    );

    typedef struct {
        int          id;
        bit          chk;
        bit          chk_ucnt;
        logic        taken;
        logic [31:0] target;
        logic [31:0] ucnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t exp_q[$];

    // reference model
    bit          m_valid  [NENT];
    logic [31:0] m_tag    [NENT];
    logic [31:0] m_target [NENT];
    int          m_ctr    [NENT];
    logic [31:0] m_ucnt, m_mcnt;

    int  n_pass = 0;
    int  n_total = 0;
    int  step_id = 0;
    bit  chk_en = 1'b0;
    bit  chk_ucnt = 1'b1;

    function automatic int pc_index(logic [31:0] pc);
        return int'((pc / 2) % NENT);
    endfunction

    function automatic logic [31:0] pc_tag(logic [31:0] pc);
        return pc / (2 * NENT);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
        end
        m_ucnt = '0;
        m_mcnt = '0;
    endfunction

    function automatic void model_lookup(output logic taken, output logic [31:0] target);
        int i;
        int off;
        i = pc_index(bif.current_pc);
        if (!bif.is_branch) begin
            taken  = 1'b0;
            target = bif.current_pc + (bif.is_rv32c ? 2 : 4);
        end else if (m_valid[i] && m_tag[i] == pc_tag(bif.current_pc)) begin
            taken  = (m_ctr[i] >= 2);
            target = m_target[i];
        end else begin
            off    = int'(bif.imm_sb);
            if (off >= 4096) off = off - 8192;
            taken  = (off < 0);
            target = bif.current_pc + off;
        end
    endfunction

    function automatic void model_update();
        int i;
        i = pc_index(bif.pc_to_update);
        if (m_valid[i] && m_tag[i] == pc_tag(bif.pc_to_update)) begin
            if (bif.branch_result) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else                   m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc_tag(bif.pc_to_update);
            m_ctr[i]   = bif.branch_result ? 2 : 1;
        end
        m_target[i] = bif.update_addr;
        if (m_ucnt != 32'hFFFF_FFFF) m_ucnt = m_ucnt + 1;
        if (bif.prediction != bif.branch_result && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
    endfunction

    // One cycle: queue expected outputs for the current inputs, then clock.
    task automatic step();
        exp_t e;
        e.id = step_id;
        e.chk = chk_en;
        e.chk_ucnt = chk_ucnt;
        model_lookup(e.taken, e.target);
        e.ucnt = m_ucnt;
        e.mcnt = m_mcnt;
        exp_q.push_back(e);
        step_id++;
        @(posedge clk);
        if (rst) model_reset();
        else if (bif.update_predictor) model_update();
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic br, input logic [12:0] imm, input logic rvc);
        bif.current_pc = pc; bif.is_branch = br; bif.imm_sb = imm; bif.is_rv32c = rvc;
    endtask

    task automatic upd(input logic en, input logic [31:0] pc, input logic [31:0] addr,
                       input logic res, input logic pred);
        bif.update_predictor = en; bif.pc_to_update = pc; bif.update_addr = addr;
        bif.branch_result = res; bif.prediction = pred;
    endtask

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("predict_taken", e.id, {31'd0, bif.predict_taken}, {31'd0, e.taken});
                    check("target_addr", e.id, bif.target_addr, e.target);
                    check("mispredict_count", e.id, bif.mispredict_count, e.mcnt);
                    if (e.chk_ucnt) check("update_count", e.id, bif.update_count, e.ucnt);
                end
            end
        end
    end

    initial begin
        int waited;
        look(32'h0, 1'b0, 13'h0, 1'b0);
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bif.direction = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // static fallback
        look(32'h100, 1'b1, 13'h1FF8, 1'b0); step();
        look(32'h100, 1'b1, 13'h0010, 1'b0); step();
        look(32'h100, 1'b0, 13'h0010, 1'b1); step();
        look(32'h100, 1'b0, 13'h0010, 1'b0); step();

        // allocate and train down
        upd(1'b1, 32'h200, 32'h240, 1'b1, 1'b0);
        look(32'h200, 1'b1, 13'h0010, 1'b0); step();
        upd(1'b0, 32'h200, 32'h240, 1'b1, 1'b0); step();
        upd(1'b1, 32'h200, 32'h240, 1'b0, 1'b1); step();
        step(); step();
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();

        // saturation and hysteresis
        upd(1'b1, 32'h200, 32'h260, 1'b1, 1'b1); step(); step(); step(); step();
        upd(1'b1, 32'h200, 32'h260, 1'b0, 1'b1); step();
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();
        upd(1'b1, 32'h200, 32'h260, 1'b0, 1'b1); step();
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();

        // aliasing: same index, different tag replaces the entry
        upd(1'b1, 32'h200, 32'h240, 1'b1, 1'b1); step(); step();
        upd(1'b1, 32'h200 + 2 * NENT, 32'h300, 1'b0, 1'b0); step();
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();
        look(32'h200 + 2 * NENT, 1'b1, 13'h1FF0, 1'b0); step();

        // reset with a coincident strobe
        rst = 1'b1;
        upd(1'b1, 32'h200, 32'h240, 1'b1, 1'b0);
        look(32'h200, 1'b1, 13'h1FF8, 1'b0); step();
        rst = 1'b0;
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();
        look(32'h200, 1'b0, 13'h0, 1'b0); step();

        // counters: 5 updates, 2 mispredicted
        look(32'h400, 1'b1, 13'h0020, 1'b0);
        upd(1'b1, 32'h400, 32'h420, 1'b1, 1'b1); step();
        upd(1'b1, 32'h400, 32'h420, 1'b1, 1'b0); step();
        upd(1'b1, 32'h402, 32'h420, 1'b0, 1'b0); step();
        upd(1'b1, 32'h404, 32'h420, 1'b0, 1'b1); step();
        upd(1'b1, 32'h400, 32'h420, 1'b1, 1'b1); step();
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();

        // randomized traffic over a few indices and tags to force hits and aliasing
        for (int n = 0; n < 400; n++) begin
            look({$urandom_range(0, 3), 7'h0} | ({26'd0, 6'($urandom_range(0, 7))} << 1)
                     | ($urandom_range(0, 1) ? 32'h1000 : 32'h0),
                 1'($urandom_range(0, 3) != 0), 13'($urandom) & 13'h1FFE, 1'($urandom));
            upd(1'($urandom_range(0, 2) != 0),
                {$urandom_range(0, 3), 7'h0} | ({26'd0, 6'($urandom_range(0, 7))} << 1),
                $urandom & 32'hFFFF_FFFE, 1'($urandom), 1'($urandom));
            bif.direction = 1'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        // update counter saturation
        upd(1'b1, 32'h600, 32'h640, 1'b1, 1'b1);
        chk_ucnt = 1'b0;
        force dut.upd_cnt = 32'hFFFF_FFFD;
        step();
        release dut.upd_cnt;
        repeat (4) step();
        m_ucnt = 32'hFFFF_FFFF;
        chk_ucnt = 1'b1;
        step(); step();
        upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
